lcd_disp_arbiter: RTL and testbench
===================================

// Module: lcd_disp_arbiter
// PURPOSE
//  Shares the single 16x2 character LCD driver between two content sources (A, B).
//  Round-robin arbitration selects one pending request and latches its two 128-bit rows.
//  The block then pulses the driver's start-show input and tracks the driver's no-busy
//  flag through one full refresh. Finally it acknowledges the winning source.
//  Sits between application logic and the LCD driver; it is the driver's only start source.
// PARAMETERS
//  HOLDOFF_CYC  50_000   min idle clk cycles between refresh completion and next launch (1 ms @ 50 MHz)
//  TIMEOUT_CYC  200_000  max clk cycles to wait for driver no-busy to fall after a launch
// PORTS
//  clk            in   1    system clock, 50 MHz
//  rst_n          in   1    reset, asynchronous, active-low
//  req            in   2    level request per source: bit0 = A, bit1 = B; held until ack
//  row1_a/row2_a  in   128  source A line 1 / line 2 text, 16 ASCII chars, char0 in [127:120]
//  row1_b/row2_b  in   128  source B line 1 / line 2 text, same packing
//  ack            out  2    one-cycle pulse to the served source on refresh completion
//  err            out  1    one-cycle pulse on launch timeout
//  busy           out  1    high in every state except S_IDLE
//  owner          out  1    index of the source latched for the current/last launch
//  drv_no_busy    in   1    driver idle flag; high = driver parked at end-of-show
//  drv_start_show out  1    one-cycle launch pulse to driver
//  drv_row_1      out  128  latched line 1 to driver
//  drv_row_2      out  128  latched line 2 to driver
// BEHAVIOUR
//  Reset: all outputs are 0 (rows, ack, err, busy, owner, drv_start_show); state S_IDLE.
//  Reset: hold-off counter = HOLDOFF_CYC-1 (expired); RR pointer last = 1, so A wins first tie.
//  Reset mid-operation aborts at once; no ack is issued; the driver is not re-pulsed.
//  FSM states and transitions:
//   S_IDLE:    go to S_LAUNCH when |req && drv_no_busy && holdoff expired.
//              Grant rule: only one req bit set -> that source; both set -> source != last.
//   S_LAUNCH:  one cycle; drv_row_1/2 <= granted rows; owner <= grant; last <= grant.
//              drv_start_show = 1 this cycle only. Always -> S_WAIT_LO.
//   S_WAIT_LO: drv_no_busy == 0 -> S_WAIT_HI. Driver may take up to one write tick to leave idle.
//              Timeout counter counts from 0 on entry; reaching TIMEOUT_CYC-1 with
//              drv_no_busy still 1 -> err pulse, no ack, -> S_IDLE; holdoff restarts.
//   S_WAIT_HI: drv_no_busy == 1 -> ack[owner] pulse (same cycle as exit); restart holdoff -> S_IDLE.
//              No timeout in this state; the driver always completes a show.
//  drv_row_1/2 hold the latched values from S_LAUNCH until the next S_LAUNCH. Source row
//  inputs may change freely after launch without affecting the display in flight.
//  Holdoff counter: restarts at 0 on leaving S_WAIT_HI or on timeout; expired at HOLDOFF_CYC-1;
//  saturates there.
//  A req dropping after launch does not abort; ack is still pulsed (source may ignore it).
//  A req rising during a refresh is served next. With both pending, service alternates A,B,A,B.
//  drv_no_busy is low throughout driver power-on init (~20 ms); S_IDLE simply waits.
//  Counters are sized $clog2(param) bits; no wrap. All outputs are registered.
//  Launch latency: 1 cycle from the S_IDLE grant condition to drv_start_show.
// TESTING  (driver model: no_busy falls 3..100_000 cycles after start, rises 40 ticks later)
//  1. req=01, no_busy=1 -> drv_start_show 1 cycle; drv_row_1==row1_a.
//     After no_busy 1->0->1 -> ack=01 for 1 cycle, busy back to 0.
//  2. req=11 held across 4 refreshes -> owner sequence 0,1,0,1; ack sequence 01,10,01,10.
//  3. Back-to-back: 2nd launch is no earlier than HOLDOFF_CYC cycles after the 1st ack
//     (check with HOLDOFF_CYC=16).
//  4. TIMEOUT_CYC=32, model never drops no_busy -> err pulse at cycle 32 after launch, ack=00.
//     Launch retried after holdoff while req is still held.
//  5. Assert rst_n=0 in S_WAIT_HI -> all outputs 0 asynchronously; no ack after release.
//     Fresh launch occurs once no_busy=1.
//  6. Change row1_a to 0x41.. during S_WAIT_HI -> drv_row_1 keeps launch value until next launch.

Source files
------------

// File: rtl/lcd_disp_arbiter_if.sv
// Source-side bundle of the LCD display arbiter: per-source requests and rows in,
// per-source ack plus status out.
interface lcd_disp_arbiter_if;
  localparam int unsigned ROW_W = 128;

  logic [1:0]       req;
  logic [ROW_W-1:0] row1_a;
  logic [ROW_W-1:0] row2_a;
  logic [ROW_W-1:0] row1_b;
  logic [ROW_W-1:0] row2_b;
  logic [1:0]       ack;
  logic             err;
  logic             busy;
  logic             owner;

  modport master (
    output req, row1_a, row2_a, row1_b, row2_b,
    input  ack, err, busy, owner
  );

  modport slave (
    input  req, row1_a, row2_a, row1_b, row2_b,
    output ack, err, busy, owner
  );
endinterface

// File: rtl/lcd_disp_arbiter.sv
// Round-robin arbiter sharing one 16x2 LCD driver between sources A and B: latches the
// winner's rows, launches a show, follows the driver's no-busy flag and acks the source.
module lcd_disp_arbiter #(
  parameter int unsigned HOLDOFF_CYC = 50_000,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_disp_arbiter_if.slave   src,
  input  logic                drv_no_busy,
  output logic                drv_start_show,
  output logic [127:0]        drv_row_1,
  output logic [127:0]        drv_row_2
);

  localparam int unsigned HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYC - 1);
  localparam logic [TW-1:0] TOUT_PRE = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_LO, S_WAIT_HI} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          last;
  logic          grant;
  logic          launch;
  logic [1:0]    ack_n;
  logic          err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hcnt  <= HOLD_MAX;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      tcnt  <= tcnt_n;
    end
  end

  // Tie goes to the source that was not served last.
  always_comb begin
    unique case (src.req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    hcnt_n  = (hcnt == HOLD_MAX) ? hcnt : hcnt + HW'(1);
    tcnt_n  = tcnt;
    launch  = 1'b0;
    ack_n   = 2'b00;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if ((|src.req) && drv_no_busy && (hcnt == HOLD_MAX)) begin
          state_n = S_LAUNCH;
          launch  = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_n = S_WAIT_LO;
        tcnt_n  = '0;
      end
      // Timeout fires as the counter reaches TIMEOUT_CYC-1 with the driver still idle.
      S_WAIT_LO: begin
        if (!drv_no_busy) begin
          state_n = S_WAIT_HI;
        end else if (tcnt == TOUT_PRE) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
          hcnt_n  = '0;
        end else begin
          tcnt_n  = tcnt + TW'(1);
        end
      end
      S_WAIT_HI: begin
        if (drv_no_busy) begin
          state_n = S_IDLE;
          ack_n   = src.owner ? 2'b10 : 2'b01;
          hcnt_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs; rows and owner change only on a launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_start_show <= 1'b0;
      drv_row_1      <= '0;
      drv_row_2      <= '0;
      src.owner      <= 1'b0;
      src.ack        <= 2'b00;
      src.err        <= 1'b0;
      src.busy       <= 1'b0;
      last           <= 1'b1;
    end else begin
      drv_start_show <= launch;
      src.ack        <= ack_n;
      src.err        <= err_n;
      src.busy       <= (state_n != S_IDLE);
      if (launch) begin
        drv_row_1 <= grant ? src.row1_b : src.row1_a;
        drv_row_2 <= grant ? src.row2_b : src.row2_a;
        src.owner <= grant;
        last      <= grant;
      end
    end
  end

endmodule

// File: tb/tb_lcd_disp_arbiter.sv
// Self-checking bench for lcd_disp_arbiter: vector table of refreshes plus directed
// sequences for power-on wait, row hold, launch timeout and mid-refresh reset.
module tb_lcd_disp_arbiter;
  localparam int unsigned H = 16;
  localparam int unsigned T = 32;

  typedef struct {
    logic [1:0]   req;
    logic         exp_owner;
    logic [1:0]   exp_ack;
    logic [127:0] exp_r1;
    logic [127:0] exp_r2;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         drv_no_busy;
  logic         drv_start_show;
  logic [127:0] drv_row_1;
  logic [127:0] drv_row_2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_dly = 3;
  int low_len = 10;
  bit stuck = 1'b0;

  logic [127:0] ra1 = "source A line 1 ";
  logic [127:0] ra2 = "source A line 2 ";
  logic [127:0] rb1 = "source B line 1 ";
  logic [127:0] rb2 = "source B line 2 ";
  logic [127:0] all_a = "AAAAAAAAAAAAAAAA";

  vec_t vecs [8];

  lcd_disp_arbiter_if bus();

  lcd_disp_arbiter #(.HOLDOFF_CYC(H), .TIMEOUT_CYC(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src            (bus),
    .drv_no_busy    (drv_no_busy),
    .drv_start_show (drv_start_show),
    .drv_row_1      (drv_row_1),
    .drv_row_2      (drv_row_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: idle low during power-on, then falls fall_dly after a start, low for low_len.
  initial begin
    drv_no_busy = 1'b0;
    repeat (20) @(negedge clk);
    drv_no_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (drv_start_show && !stuck) begin
        repeat (fall_dly) @(negedge clk);
        drv_no_busy = 1'b0;
        repeat (low_len) @(negedge clk);
        drv_no_busy = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name, output int t);
    bit found = 1'b0;
    t = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (drv_start_show) begin
        found = 1'b1;
        t = cyc;
      end
    end
    chk({name, " launch seen"}, 128'(found), 128'(1));
  endtask

  task automatic wait_ack(input string name, output int t, output logic [1:0] a);
    bit found = 1'b0;
    t = 0;
    a = 2'b00;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (|bus.ack) begin
        found = 1'b1;
        t = cyc;
        a = bus.ack;
      end
    end
    chk({name, " ack seen"}, 128'(found), 128'(1));
  endtask

  task automatic wait_low();
    for (int n = 0; n < 400 && drv_no_busy; n++) @(negedge clk);
  endtask

  initial begin
    int ts, ta, te, tl, t2, starts;
    logic [1:0] av;
    bit ack_seen, err_seen;

    vecs[0] = '{2'b01, 1'b0, 2'b01, ra1, ra2};
    vecs[1] = '{2'b11, 1'b1, 2'b10, rb1, rb2};
    vecs[2] = '{2'b11, 1'b0, 2'b01, ra1, ra2};
    vecs[3] = '{2'b11, 1'b1, 2'b10, rb1, rb2};
    vecs[4] = '{2'b11, 1'b0, 2'b01, ra1, ra2};
    vecs[5] = '{2'b10, 1'b1, 2'b10, rb1, rb2};
    vecs[6] = '{2'b10, 1'b1, 2'b10, rb1, rb2};
    vecs[7] = '{2'b01, 1'b0, 2'b01, ra1, ra2};

    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.row1_a = ra1; bus.row2_a = ra2;
    bus.row1_b = rb1; bus.row2_b = rb2;
    repeat (3) @(negedge clk);
    chk("rst busy",  128'(bus.busy), 128'(0));
    chk("rst ack",   128'(bus.ack), 128'(0));
    chk("rst err",   128'(bus.err), 128'(0));
    chk("rst owner", 128'(bus.owner), 128'(0));
    chk("rst start", 128'(drv_start_show), 128'(0));
    chk("rst row1",  drv_row_1, 128'(0));
    chk("rst row2",  drv_row_2, 128'(0));
    rst_n = 1'b1;

    // Driver still in power-on init: a pending request must not launch.
    bus.req = 2'b01;
    starts = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (drv_start_show) starts++;
    end
    chk("poweron no launch", 128'(starts), 128'(0));
    chk("poweron busy", 128'(bus.busy), 128'(0));

    ta = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req = vecs[i].req;
      wait_start($sformatf("v%0d", i), ts);
      if (i > 0) chk($sformatf("v%0d holdoff gap", i), 128'(ts - ta), 128'(H));
      chk($sformatf("v%0d owner", i), 128'(bus.owner), 128'(vecs[i].exp_owner));
      chk($sformatf("v%0d row1", i), drv_row_1, vecs[i].exp_r1);
      chk($sformatf("v%0d row2", i), drv_row_2, vecs[i].exp_r2);
      chk($sformatf("v%0d busy", i), 128'(bus.busy), 128'(1));
      @(negedge clk);
      chk($sformatf("v%0d start width", i), 128'(drv_start_show), 128'(0));
      wait_ack($sformatf("v%0d", i), ta, av);
      chk($sformatf("v%0d ack", i), 128'(av), 128'(vecs[i].exp_ack));
      @(negedge clk);
      chk($sformatf("v%0d ack width", i), 128'(bus.ack), 128'(0));
      chk($sformatf("v%0d busy idle", i), 128'(bus.busy), 128'(0));
    end

    // Row hold: source text changing mid-refresh is not shown until the next launch.
    wait_start("hold", ts);
    chk("hold row1 launch", drv_row_1, ra1);
    bus.row1_a = all_a;
    wait_low();
    @(negedge clk);
    chk("hold row1 wait_hi", drv_row_1, ra1);
    wait_ack("hold", ta, av);
    chk("hold ack", 128'(av), 128'(2'b01));
    chk("hold row1 after ack", drv_row_1, ra1);
    wait_start("hold next", ts);
    chk("hold row1 next", drv_row_1, all_a);
    wait_ack("hold next", ta, av);
    bus.row1_a = ra1;

    // Launch timeout: driver never leaves idle.
    stuck = 1'b1;
    wait_start("tout", tl);
    ack_seen = 1'b0;
    err_seen = 1'b0;
    te = 0;
    for (int n = 0; n < 100 && !err_seen; n++) begin
      @(negedge clk);
      if (|bus.ack) ack_seen = 1'b1;
      if (bus.err) begin
        err_seen = 1'b1;
        te = cyc;
      end
    end
    chk("tout err seen", 128'(err_seen), 128'(1));
    chk("tout err time", 128'(te - tl), 128'(T));
    chk("tout no ack", 128'(ack_seen), 128'(0));
    @(negedge clk);
    chk("tout err width", 128'(bus.err), 128'(0));
    stuck = 1'b0;
    wait_start("retry", t2);
    chk("retry gap", 128'(t2 - te), 128'(H));
    wait_ack("retry", ta, av);
    chk("retry ack", 128'(av), 128'(2'b01));

    // Reset during S_WAIT_HI: outputs clear at once, no ack, A wins the first tie after.
    bus.req = 2'b11;
    wait_start("rst", ts);
    chk("rst pre owner", 128'(bus.owner), 128'(1));
    wait_low();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy",  128'(bus.busy), 128'(0));
    chk("arst owner", 128'(bus.owner), 128'(0));
    chk("arst row1",  drv_row_1, 128'(0));
    chk("arst row2",  drv_row_2, 128'(0));
    chk("arst ack",   128'(bus.ack), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    starts = 0;
    for (int n = 0; n < 300 && starts == 0; n++) begin
      @(negedge clk);
      if (|bus.ack) ack_seen = 1'b1;
      if (drv_start_show) starts++;
    end
    chk("post rst launch", 128'(starts), 128'(1));
    chk("post rst no ack", 128'(ack_seen), 128'(0));
    chk("post rst owner", 128'(bus.owner), 128'(0));
    chk("post rst row1", drv_row_1, ra1);
    chk("post rst no_busy", 128'(drv_no_busy), 128'(1));
    wait_ack("post rst", ta, av);
    chk("post rst ack", 128'(av), 128'(2'b01));
    bus.req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
